// File: rtl/gate_test_seq_if.sv
// gate_test_seq_if: the two handshakes of the campaign sequencer.
//   - Tester side: DUT_START pulse out, DUT_FINISH / DUT_ERROR back.
//   - Result side: byte stream with valid/ready semantics. The producer
//     raises RES_VALID with RES_DATA/RES_LAST and must hold all three
//     unchanged until it samples RES_READY high on a rising edge; a byte
//     transfers on exactly those edges where RES_VALID & RES_READY. The
//     consumer may drive RES_READY freely and independently of RES_VALID.
// master = sequencer, slave = tester + host-link serializer.
interface gate_test_seq_if;
  logic        DUT_START;
  logic        DUT_FINISH;
  logic [31:0] DUT_ERROR;
  logic        RES_VALID;
  logic        RES_READY;
  logic [7:0]  RES_DATA;
  logic        RES_LAST;

  modport master (
    output DUT_START,
    input  DUT_FINISH,
    input  DUT_ERROR,
    output RES_VALID,
    output RES_DATA,
    output RES_LAST,
    input  RES_READY
  );

  modport slave (
    input  DUT_START,
    output DUT_FINISH,
    output DUT_ERROR,
    input  RES_VALID,
    input  RES_DATA,
    input  RES_LAST,
    output RES_READY
  );
endinterface

// File: rtl/gate_test_seq.sv
// gate_test_seq: runs RUNS back-to-back passes on one gate tester, sums
// (saturating) and maxes the per-pass error counts, then streams a 10-byte
// result frame: header, run count, total[31:0], worst[31:0], MSB first.
// Optional build macro GATE_SEQ_TIMEOUT_EN adds a per-pass watchdog of
// TIMEOUT_CYC cycles; a timed-out pass adds nothing to the accumulators and
// turns the header from 0xA5 into 0xE5.
module gate_test_seq #(
  parameter int unsigned RUNS = 4,
  parameter int unsigned GAP  = 8
`ifdef GATE_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1048576
`endif
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            RUN_REQ,
  output logic            BUSY,
  output logic            DONE,
  output logic [2:0]      dbg_state,
  gate_test_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_SEND  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam logic [7:0]  RUNS_B   = 8'(RUNS);
  localparam logic [15:0] GAP_LOAD = 16'(GAP - 1);
`ifdef GATE_SEQ_TIMEOUT_EN
  localparam logic [20:0] WD_LAST  = 21'(TIMEOUT_CYC - 1);
`endif

  state_t      state;
  logic        fin_q;
  logic [31:0] total;
  logic [31:0] worst;
  logic [7:0]  run_idx;
  logic [3:0]  byte_idx;
  logic [15:0] gap_cnt;
  logic        timed_out;
`ifdef GATE_SEQ_TIMEOUT_EN
  logic [20:0] wd_cnt;
`endif

  logic        fin_edge;
  logic [32:0] sum_ext;

  assign fin_edge  = bus.DUT_FINISH & ~fin_q;
  assign sum_ext   = {1'b0, total} + {1'b0, bus.DUT_ERROR};
  assign dbg_state = state;

  // Frame byte at position idx; header flags any timed-out pass.
  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic to_flag,
                                            input logic [7:0] runs_n,
                                            input logic [31:0] tot, input logic [31:0] wst);
    logic [7:0] b;
    case (idx)
      4'd0:    b = to_flag ? 8'hE5 : 8'hA5;
      4'd1:    b = runs_n;
      4'd2:    b = tot[31:24];
      4'd3:    b = tot[23:16];
      4'd4:    b = tot[15:8];
      4'd5:    b = tot[7:0];
      4'd6:    b = wst[31:24];
      4'd7:    b = wst[23:16];
      4'd8:    b = wst[15:8];
      4'd9:    b = wst[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Campaign FSM with registered outputs; DUT_START and DONE default low so
  // they can only ever be single-cycle pulses.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= S_IDLE;
      fin_q         <= 1'b0;
      total         <= 32'd0;
      worst         <= 32'd0;
      run_idx       <= 8'd0;
      byte_idx      <= 4'd0;
      gap_cnt       <= 16'd0;
      timed_out     <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      bus.DUT_START <= 1'b0;
      bus.RES_VALID <= 1'b0;
      bus.RES_DATA  <= 8'h00;
      bus.RES_LAST  <= 1'b0;
`ifdef GATE_SEQ_TIMEOUT_EN
      wd_cnt        <= 21'd0;
`endif
    end else begin
      fin_q         <= bus.DUT_FINISH;
      bus.DUT_START <= 1'b0;
      DONE          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (RUN_REQ) begin
            total     <= 32'd0;
            worst     <= 32'd0;
            run_idx   <= 8'd0;
            timed_out <= 1'b0;
            BUSY      <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          bus.DUT_START <= 1'b1;
`ifdef GATE_SEQ_TIMEOUT_EN
          wd_cnt        <= 21'd0;
`endif
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (fin_edge) begin
            total   <= sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
            worst   <= (bus.DUT_ERROR > worst) ? bus.DUT_ERROR : worst;
            run_idx <= run_idx + 8'd1;
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end
`ifdef GATE_SEQ_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            timed_out <= 1'b1;
            run_idx   <= run_idx + 8'd1;
            gap_cnt   <= GAP_LOAD;
            state     <= S_GAP;
          end else begin
            wd_cnt <= wd_cnt + 21'd1;
          end
`endif
        end
        S_GAP: begin
          // A FINISH still held high here is ignored; the next pass only
          // starts once the tester has released it.
          if (gap_cnt != 16'd0) begin
            gap_cnt <= gap_cnt - 16'd1;
          end else if (!bus.DUT_FINISH) begin
            if (run_idx == RUNS_B) begin
              byte_idx      <= 4'd0;
              bus.RES_VALID <= 1'b1;
              bus.RES_DATA  <= frame_byte(4'd0, timed_out, run_idx, total, worst);
              bus.RES_LAST  <= 1'b0;
              state         <= S_SEND;
            end else begin
              state <= S_START;
            end
          end
        end
        S_SEND: begin
          if (bus.RES_READY) begin
            if (byte_idx == 4'd9) begin
              bus.RES_VALID <= 1'b0;
              bus.RES_LAST  <= 1'b0;
              bus.RES_DATA  <= 8'h00;
              DONE          <= 1'b1;
              state         <= S_FIN;
            end else begin
              byte_idx     <= byte_idx + 4'd1;
              bus.RES_DATA <= frame_byte(byte_idx + 4'd1, timed_out, run_idx, total, worst);
              bus.RES_LAST <= (byte_idx == 4'd8);
            end
          end
        end
        S_FIN: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_test_seq.md
# gate_test_seq

Campaign sequencer upstream of the single-gate testers (e.g. the NOT-gate tester). On request it issues RUNS back-to-back test passes to one tester via its START/FINISH/ERROR interface, accumulates per-pass error counts, and emits a 10-byte result frame over a valid/ready byte stream for the host-link serializer.

## Interface
- RUNS, 4: passes per campaign, 1..255.
- GAP, 8: idle cycles between a pass's FINISH capture and the next DUT_START, ≥2.
- TIMEOUT_CYC, 1048576: per-pass watchdog limit in cycles; used only with GATE_SEQ_TIMEOUT_EN.

- sys_clk  in  1  clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- RUN_REQ  in  1  campaign request, sampled in IDLE only.
- BUSY  out  1  high from the cycle after RUN_REQ acceptance until the return to IDLE.
- DUT_START  out  1  one-cycle start pulse to the tester.
- DUT_FINISH  in  1  tester finish; may stay high several cycles.
- DUT_ERROR  in  32  tester error count; valid while DUT_FINISH is high.
- RES_VALID  out  1  result byte valid.
- RES_READY  in  1  consumer ready.
- RES_DATA  out  8  result byte.
- RES_LAST  out  1  high with the final frame byte.
- DONE  out  1  one-cycle pulse after the final byte transfers.

## Operation
- States: IDLE, START, WAIT, GAP, SEND, FIN.
- IDLE: RUN_REQ=1 → clear accumulators, run_idx=0 → START.
- START: DUT_START=1 for exactly one cycle → WAIT.
- WAIT: fin_q = registered DUT_FINISH; rising edge (DUT_FINISH & ~fin_q) captures DUT_ERROR.
  - total += DUT_ERROR, saturating at 0xFFFFFFFF.
  - worst = max(worst, DUT_ERROR).
  - run_idx += 1 → GAP.
- GAP: counts GAP cycles; exits only once the count has expired and DUT_FINISH=0. Then run_idx==RUNS → SEND, else → START.
- SEND: 10-byte frame, MSB first: 0xA5 header (0xE5 if any pass timed out), run_idx, total[31:0], worst[31:0]. Byte index advances on RES_VALID & RES_READY. Transfer of byte 9 → FIN.
- FIN: DONE=1 for one cycle, BUSY drops → IDLE.
- RUN_REQ while BUSY is ignored, not queued.
- DUT_FINISH high in IDLE/START/GAP/SEND has no effect. Only a rising edge seen in WAIT captures.

## Timing
- Reset: BUSY, DUT_START, RES_VALID, RES_LAST, DONE = 0; RES_DATA = 0x00; accumulators, run_idx, byte index, fin_q = 0; state IDLE.
- Reset mid-campaign aborts immediately. No frame is emitted. DUT_START is never re-pulsed by reset.
- RUN_REQ at cycle t: BUSY=1 at t+1, DUT_START=1 at t+2.
- FINISH rising edge at cycle f: accumulators updated at f+1. Next DUT_START no earlier than f+GAP+2.
- Stream rules:
  - RES_VALID rises the cycle SEND is entered.
  - RES_DATA and RES_LAST hold while RES_VALID & ~RES_READY.
  - With RES_READY held high, one byte per cycle: 10 cycles.
  - RES_VALID drops the cycle after the last transfer, coincident with DONE=1.
- Worst-case compare is unsigned 32-bit. Saturation holds at 0xFFFFFFFF once reached.

## Configuration
- GATE_SEQ_TIMEOUT_EN defined:
  - A 21-bit watchdog counts cycles in WAIT.
  - Reaching TIMEOUT_CYC without a FINISH edge ends the pass: no accumulator update, sticky timeout flag set, run_idx += 1 → GAP.
  - Header byte becomes 0xE5.
- Undefined: no watchdog; WAIT holds indefinitely; header always 0xA5.

## Test plan
- RUNS=4; behavioural tester returns FINISH after 100 cycles with ERROR 0,3,1,0 → frame A5 04 00000004 00000003, DONE once, exactly 4 DUT_START pulses spaced ≥ GAP+2 cycles after each FINISH edge.
- Tester holds FINISH high 5 cycles per pass → each pass captured exactly once; total equals the sum of the four ERROR values.
- ERROR=0xFFFFFFF0 on pass 1 and 0x20 on pass 2 (RUNS=2) → total 0xFFFFFFFF, worst 0xFFFFFFF0.
- RES_READY toggled pseudo-randomly during SEND → all 10 bytes delivered in order with no drops or repeats, RES_LAST only on byte 9; RUN_REQ pulses during BUSY are ignored.
- sys_rst asserted during pass 2 WAIT → all outputs at reset values next cycle; a fresh RUN_REQ yields a full, clean campaign.
- With GATE_SEQ_TIMEOUT_EN and TIMEOUT_CYC=1000, tester never finishes on pass 3 → header E5, run count 04, totals exclude pass 3.
